// File: rtl/act_pkg.sv
// Shared types for the activation pipeline: the per-beat activation mode encoding.
package act_pkg;

  localparam int ACT_MODE_W = 2;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_CLAMP = 2'd2,
    ACT_LEAKY = 2'd3
  } act_mode_t;

endpackage

// File: rtl/act_lane.sv
// Single-lane combinational activation. Leaky ReLU is built only with ACT_RELU_PIPE_LEAKY_EN;
// without it, mode 3 falls back to plain ReLU and no shifter exists.
module act_lane
  import act_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CLAMP_MAX  = 4096,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [WIDTH-1:0] x,
  input  act_mode_t               mode,
  output logic signed [WIDTH-1:0] y
);

  localparam logic signed [WIDTH-1:0] CMAX = WIDTH'(CLAMP_MAX);

  if (CLAMP_MAX <= 0 || CLAMP_MAX > (2 ** (WIDTH - 1)) - 1) begin : g_bad_clamp
    $error("act_lane: CLAMP_MAX must be positive and fit in WIDTH");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT >= WIDTH) begin : g_bad_shift
    $error("act_lane: LEAK_SHIFT must be in [1, WIDTH-1]");
  end

  logic neg;
  assign neg = x[WIDTH-1];

  always_comb begin
    y = x;
    case (mode)
      ACT_PASS:  y = x;
      ACT_RELU:  y = neg ? '0 : x;
      ACT_CLAMP: y = neg ? '0 : ((x > CMAX) ? CMAX : x);
`ifdef ACT_RELU_PIPE_LEAKY_EN
      // arithmetic shift floors, so the most-negative input cannot overflow
      ACT_LEAKY: y = neg ? (x >>> LEAK_SHIFT) : x;
`else
      ACT_LEAKY: y = neg ? '0 : x;
`endif
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/act_relu_pipe.sv
// Two-stage multi-lane activation pipe with valid/ready and a saturating negative-lane counter.
// Optional leaky mode via ACT_RELU_PIPE_LEAKY_EN (see act_lane).
module act_relu_pipe
  import act_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 4,
  parameter int CLAMP_MAX  = 4096,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic [ACT_MODE_W-1:0]       in_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic [CNT_W-1:0]            neg_cnt,
  input  logic                        cnt_clr
);

  localparam int STAGES = 2;
  localparam int PW     = $clog2(CHANNELS + 1);

  logic [STAGES:1]                  vld_pipe;
  logic [CHANNELS-1:0][WIDTH-1:0]   in_lanes, s1_data, s2_data, act_data;
  act_mode_t                        s1_mode;
  logic                             advance;

  assign in_lanes  = in_data;
  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = s2_data;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    act_lane #(
      .WIDTH      (WIDTH),
      .CLAMP_MAX  (CLAMP_MAX),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x    (s1_data[i]),
      .mode (s1_mode),
      .y    (act_data[i])
    );
  end

  // the whole pipe moves as one; a stalled S2 freezes S1 as well
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s1_mode  <= ACT_PASS;
      s2_data  <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[1], in_valid};
      s1_data  <= in_lanes;
      s1_mode  <= act_mode_t'(in_mode);
      s2_data  <= act_data;
    end
  end

  logic [PW-1:0]  neg_pop;
  logic [CNT_W:0] cnt_sum;

  always_comb begin
    neg_pop = '0;
    for (int i = 0; i < CHANNELS; i++) neg_pop = neg_pop + PW'(in_lanes[i][WIDTH-1]);
    cnt_sum = {1'b0, neg_cnt} + (CNT_W + 1)'(neg_pop);
  end

  // clear wins over a same-cycle count; carry-out means saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      neg_cnt <= '0;
    else if (cnt_clr)
      neg_cnt <= '0;
    else if (in_valid && in_ready)
      neg_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_act_relu_pipe.sv
// Randomized bench with a queue-based reference model; a narrow-counter twin checks saturation.
module tb_act_relu_pipe;
  localparam int W = 16, C = 4, CMAX = 4096, LS = 3;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic           in_valid = 0, out_ready = 0, cnt_clr = 0;
  logic [C*W-1:0] in_data = '0;
  logic [1:0]     in_mode = '0;
  logic           in_ready, out_valid, in_ready_c, out_valid_c;
  logic [C*W-1:0] out_data, out_data_c;
  logic [31:0]    neg_cnt;
  logic [3:0]     neg_cnt_c;

  act_relu_pipe #(.WIDTH(W), .CHANNELS(C), .CLAMP_MAX(CMAX), .LEAK_SHIFT(LS), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .neg_cnt(neg_cnt), .cnt_clr(cnt_clr));

  act_relu_pipe #(.WIDTH(W), .CHANNELS(C), .CLAMP_MAX(CMAX), .LEAK_SHIFT(LS), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .neg_cnt(neg_cnt_c), .cnt_clr(cnt_clr));

  int             n_vec = 0, n_bad = 0;
  logic [C*W-1:0] exp_q[$];
  longint         cnt_ref = 0, cntc_ref = 0;
  bit             prev_stall = 0;
  logic [C*W-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int act_ref(input int x, input int m);
    case (m)
      0: return x;
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? 0 : ((x > CMAX) ? CMAX : x);
`ifdef ACT_RELU_PIPE_LEAKY_EN
      default: return (x < 0) ? (x - ((1 << LS) - 1)) / (1 << LS) : x;
`else
      default: return (x < 0) ? 0 : x;
`endif
    endcase
  endfunction

  function automatic logic [C*W-1:0] expect_beat(input logic [C*W-1:0] d, input int m);
    logic [C*W-1:0] r;
    logic signed [W-1:0] v;
    int y;
    r = '0;
    for (int i = 0; i < C; i++) begin
      v = d[i*W +: W];
      y = act_ref(int'(v), m);
      r[i*W +: W] = y[W-1:0];
    end
    return r;
  endfunction

  function automatic int negs(input logic [C*W-1:0] d);
    logic signed [W-1:0] v;
    int n;
    n = 0;
    for (int i = 0; i < C; i++) begin
      v = d[i*W +: W];
      if (v < 0) n++;
    end
    return n;
  endfunction

  function automatic logic [C*W-1:0] pack(input int a, input int b, input int c, input int d);
    logic [31:0] t[4];
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    return {t[3][W-1:0], t[2][W-1:0], t[1][W-1:0], t[0][W-1:0]};
  endfunction

  // per-cycle compare against the model; acceptance is evaluated for the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", {62'd0, out_valid, out_valid_c}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_neg_cnt", {28'd0, neg_cnt_c, neg_cnt}, 64'd0);
      exp_q.delete();
      cnt_ref = 0; cntc_ref = 0; prev_stall = 0;
    end else begin
      chk("in_ready", {62'd0, in_ready, in_ready_c}, {62'd0, {2{!out_valid || out_ready}}});
      chk("neg_cnt", {28'd0, neg_cnt_c, neg_cnt}, {28'd0, cntc_ref[3:0], cnt_ref[31:0]});
      chk("twin_valid", {63'd0, out_valid_c}, {63'd0, exp_q.size() != 0 && out_valid});
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL spurious_beat: got %h expected no beat at %0t", out_data, $time);
        end else begin
          prev_data = exp_q.pop_front();
          chk("beat", out_data, prev_data);
          chk("beat_twin", out_data_c, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (cnt_clr) begin
        cnt_ref = 0; cntc_ref = 0;
      end else if (in_valid && in_ready) begin
        cnt_ref  = cnt_ref + negs(in_data);
        cntc_ref = cntc_ref + negs(in_data);
        if (cnt_ref > 64'hFFFF_FFFF) cnt_ref = 64'hFFFF_FFFF;
        if (cntc_ref > 15) cntc_ref = 15;
      end
      if (in_valid && in_ready) exp_q.push_back(expect_beat(in_data, int'(in_mode)));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // one isolated beat with out_ready high; result checked right after edge N+1
  task automatic send_one(input string name, input logic [C*W-1:0] d, input logic [1:0] m,
                          input logic [C*W-1:0] exp);
    in_valid = 1; in_data = d; in_mode = m;
    step();
    in_valid = 0;
    step();
    chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk(name, out_data, exp);
    step(); step();
  endtask

  function automatic logic [W-1:0] rand_lane();
    case ($urandom % 7)
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'(CMAX);
      4: return 16'(CMAX + 1);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int guard, k, cyc;
    bit acc;
    logic [C*W-1:0] nd;
    rst_n = 0;
    repeat (3) step();
    chk("lit_reset_valid", {63'd0, out_valid}, 64'd0);
    chk("lit_reset_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1; out_ready = 1;
    step();

    send_one("lit_relu", pack(-5, 0, 7, -32768), 2'd1, pack(0, 0, 7, 0));
    chk("lit_cnt2", {32'd0, neg_cnt}, 64'd2);
    send_one("lit_clamp", pack(5000, 4096, -1, 100), 2'd2, pack(4096, 4096, 0, 100));
`ifdef ACT_RELU_PIPE_LEAKY_EN
    send_one("lit_leaky", pack(-16, -1, -32768, 9), 2'd3, pack(-2, -1, -4096, 9));
`else
    send_one("lit_leaky", pack(-16, -1, -32768, 9), 2'd3, pack(0, 0, 0, 9));
`endif

    // narrow counter saturation, then clear beating a same-cycle negative beat
    in_valid = 1; in_data = pack(-1, -2, -3, -4); in_mode = 2'd0;
    repeat (4) step();
    in_valid = 0;
    step();
    chk("lit_sat15", {60'd0, neg_cnt_c}, 64'd15);
    in_valid = 1; cnt_clr = 1;
    step();
    in_valid = 0; cnt_clr = 0;
    chk("lit_clr", {28'd0, neg_cnt_c, neg_cnt}, 64'd0);
    repeat (3) step();

    // backpressure: 8 beats, random out_ready with a 5-cycle hard stall
    k = 0; guard = 0; cyc = 0;
    while (k < 8 && guard < 200) begin
      in_valid = 1;
      in_data = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      in_mode = 2'($urandom);
      do begin
        out_ready = (cyc >= 2 && cyc < 7) ? 1'b0 : 1'($urandom);
        #1; acc = in_ready;
        @(posedge clk); #1;
        cyc++; guard++;
      end while (!acc && guard < 200);
      if (acc) k++;
    end
    if (guard >= 200) begin
      n_vec++; n_bad++;
      $display("FAIL bp_timeout: got %0d beats expected 8", k);
    end
    in_valid = 0; out_ready = 1;
    repeat (4) step();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // reset with both stages full
    out_ready = 0; in_valid = 1; in_data = pack(1, 2, 3, 4); in_mode = 2'd0;
    step();
    in_data = pack(5, 6, 7, 8);
    step();
    in_valid = 0;
    chk("full_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 0; #1;
    chk("lit_rst_flush", {63'd0, out_valid}, 64'd0);
    step();
    rst_n = 1; out_ready = 1;
    step();
    send_one("lit_after_rst", pack(-9, 9, -100, 100), 2'd1, pack(0, 9, 0, 100));

    // random soak
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      cnt_clr   = ($urandom % 64) == 0;
      in_mode   = 2'($urandom);
      nd = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      in_data   = nd;
      step();
    end
    in_valid = 0; out_ready = 1; cnt_clr = 0;
    repeat (5) step();
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
